// File: rtl/note_sequencer.sv
// Melody step sequencer: plays a programmed list of (half-period, duration)
// steps. It drives a tone generator's period and enable, with a fixed one-tick
// articulation gap after each played note.
module note_sequencer #(
  parameter  int DEPTH    = 16,
  parameter  int TICK_DIV = 500000,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [16:0]   wr_period,
  input  logic [7:0]    wr_dur,
  input  logic [AW-1:0] length,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic [16:0]   period,
  output logic          sound,
  output logic          done
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  // Pattern memory: half-period and duration per step
  logic [16:0] mem_period [DEPTH];
  logic [7:0]  mem_dur    [DEPTH];

  state_t        state_q;
  logic [AW-1:0] step_q;
  logic [AW-1:0] len_q;
  logic [16:0]   period_q;
  logic [7:0]    rem_q;
  logic [PW-1:0] presc_q;
  logic          busy_q;
  logic          sound_q;
  logic          done_q;

  // End-of-step decision shared by FETCH (skipped step) and GAP
  state_t        eos_state_d;
  logic [AW-1:0] eos_step_d;
  logic          eos_done_d;
  logic          eos_busy_d;

  // Fetched step data (read before any same-cycle write lands)
  logic [16:0]   fetch_period;
  logic [7:0]    fetch_dur;

  assign fetch_period = mem_period[step_q];
  assign fetch_dur    = mem_dur[step_q];

  // Pattern memory write port, honoured in every state
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_period[wr_addr] <= wr_period;
      mem_dur[wr_addr]    <= wr_dur;
    end
  end

  // Next step after the current one finishes: advance, wrap on loop, or end the pass
  always_comb begin
    eos_state_d = FETCH;
    eos_step_d  = step_q;
    eos_done_d  = 1'b0;
    eos_busy_d  = 1'b1;
    if (step_q != len_q) begin
      eos_step_d = step_q + 1'b1;
    end else if (loop) begin
      eos_step_d = '0;
    end else begin
      eos_state_d = IDLE;
      eos_done_d  = 1'b1;
      eos_busy_d  = 1'b0;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      len_q    <= '0;
      period_q <= '0;
      rem_q    <= '0;
      presc_q  <= '0;
      busy_q   <= 1'b0;
      sound_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a simultaneous start
        state_q <= IDLE;
        step_q  <= '0;
        rem_q   <= '0;
        presc_q <= '0;
        busy_q  <= 1'b0;
        sound_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            sound_q <= 1'b0;
            if (start) begin
              state_q <= FETCH;
              step_q  <= '0;
              len_q   <= length;
              busy_q  <= 1'b1;
            end
          end
          FETCH: begin
            period_q <= fetch_period;
            rem_q    <= fetch_dur;
            presc_q  <= '0;
            if (fetch_dur != 8'd0) begin
              state_q <= PLAY;
              sound_q <= (fetch_period != 17'd0);
            end else begin
              // Zero-duration step is skipped without PLAY or GAP
              state_q <= eos_state_d;
              step_q  <= eos_step_d;
              done_q  <= eos_done_d;
              busy_q  <= eos_busy_d;
            end
          end
          PLAY: begin
            if (presc_q == PRESC_MAX) begin
              presc_q <= '0;
              if (rem_q == 8'd1) begin
                state_q <= GAP;
                sound_q <= 1'b0;
                rem_q   <= '0;
              end else begin
                rem_q <= rem_q - 8'd1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          GAP: begin
            if (presc_q == PRESC_MAX) begin
              presc_q <= '0;
              state_q <= eos_state_d;
              step_q  <= eos_step_d;
              done_q  <= eos_done_d;
              busy_q  <= eos_busy_d;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            sound_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign step   = step_q;
  assign period = period_q;
  assign sound  = sound_q;
  assign done   = done_q;

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001: Parameter DEPTH, default 16, number of melody steps in pattern memory (power of two).
REQ-002: Parameter TICK_DIV, default 500000, clk cycles per duration tick (10 ms at 50 MHz); set to 4 in simulation.
REQ-003: clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004: reset  input  1  asynchronous, active-high; clears all state and outputs.
REQ-005: wr_en  input  1  write one step into pattern memory this cycle.
REQ-006: wr_addr  input  log2(DEPTH)  step index written.
REQ-007: wr_period  input  17  tone half-period in clk cycles; 0 = rest.
REQ-008: wr_dur  input  8  note duration in ticks; 0 = skip step.
REQ-009: length  input  log2(DEPTH)  index of last step played; sampled on start.
REQ-010: loop  input  1  restart at step 0 after last step; sampled at end of each pass.
REQ-011: start  input  1  single-cycle pulse, begin playback at step 0.
REQ-012: stop  input  1  single-cycle pulse, abort playback.
REQ-013: busy  output  1  high in every state except IDLE.
REQ-014: step  output  log2(DEPTH)  index of current step.
REQ-015: period  output  17  half-period for the tone generator (clkdivider input).
REQ-016: sound  output  1  tone-generator enable.
REQ-017: done  output  1  one-cycle pulse when a non-looping pass completes.

Function
REQ-018: FSM states SHALL be IDLE, FETCH, PLAY, GAP; all outputs registered.
REQ-019: IDLE: start=1 -> FETCH, step=0, latched length captured; start ignored in any other state.
REQ-020: FETCH (exactly 1 cycle): period and remaining-duration latched from mem[step]; tick prescaler cleared; dur!=0 -> PLAY, dur==0 -> end-of-step handling (REQ-023) without entering PLAY or GAP.
REQ-021: PLAY: sound = (period!=0); prescaler counts 0..TICK_DIV-1, each wrap decrements remaining; state lasts exactly dur*TICK_DIV cycles, then -> GAP.
REQ-022: GAP: sound=0 for exactly TICK_DIV cycles (articulation), period held, then end-of-step handling.
REQ-023: End-of-step: step!=length -> step+1, FETCH; step==length and loop=1 -> step=0, FETCH; step==length and loop=0 -> done=1 for one cycle, IDLE.
REQ-024: Step-to-step spacing for a played note SHALL be 1 + (dur+1)*TICK_DIV cycles.
REQ-025: stop=1 in any state SHALL force IDLE next cycle with sound=0, step=0, no done pulse; stop wins over simultaneous start.
REQ-026: wr_en SHALL be honoured in every state; a write to the address being fetched in the same cycle SHALL be seen by the next fetch only (FETCH reads old data).
REQ-027: Changing length or loop during playback SHALL NOT affect the current pass for length; loop takes effect at the next end of pass.
REQ-028: Counters SHALL NOT wrap: remaining is 8 bits, prescaler sized for TICK_DIV-1; dur=255 legal.
REQ-029: In IDLE, sound=0 and period retains its last value.

Reset
REQ-030: On reset: state=IDLE, busy=0, step=0, period=0, sound=0, done=0, prescaler and remaining cleared; pattern memory contents undefined unless rewritten.
REQ-031: Reset asserted mid-note SHALL drop sound within the same cycle edge (asynchronous); after release the block stays in IDLE until a new start.

Verification (TICK_DIV=4)
REQ-032: Write steps 0..2 = (113636,2),(0,1),(75757,3), length=2, loop=0, start -> sound high 8 cycles, period=113636; gap 4; step1 sound low 4+4; step2 sound high 12, gap 4; done pulse once; busy falls same cycle.
REQ-033: Step 1 with dur=0 -> FETCH of step 1 followed directly by FETCH of step 2; no PLAY/GAP cycles for step 1.
REQ-034: loop=1, length=0, dur=1 -> step stays 0, sound pattern 4 high/4 low/1 low (FETCH) repeating, no done pulse; stop -> busy=0, sound=0 next cycle.
REQ-035: start and stop asserted same cycle in IDLE -> remains IDLE; start pulsed during PLAY -> no restart, step unchanged.
REQ-036: Reset asserted during PLAY -> sound=0, busy=0, period=0 immediately; start after release replays from step 0.
